// File: rtl/comma_aligner.sv
// Serial 8B/10B comma aligner: frames a recovered bit stream into 10-bit words
// on K28.5 boundaries and tracks link synchronisation (LOS -> ACQ -> SYNC).

module comma_aligner_chk (
  input logic       clk,
  input logic       reset,
  input logic       dout_valid,
  input logic       realign,
  input logic [3:0] cnt
);
  a_realign_has_word: assert property (@(posedge clk) disable iff (reset) realign |-> dout_valid);
  a_cnt_in_range:     assert property (@(posedge clk) disable iff (reset) cnt <= 4'd9);
endmodule

module comma_aligner (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_bit,
  input  logic       rx_bit_valid,
  input  logic       align_en,
  input  logic       code_err,
  input  logic       code_err_valid,
  output logic [9:0] dout,
  output logic       dout_valid,
  output logic       comma_det,
  output logic       realign,
  output logic       sync_status
);

  typedef enum logic [1:0] {
    ST_LOS  = 2'd0,
    ST_ACQ  = 2'd1,
    ST_SYNC = 2'd2
  } state_t;

  function automatic logic is_k28_5(input logic [9:0] word);
    return (word == 10'h17C) || (word == 10'h283);
  endfunction

  logic [9:0] r_sr;
  logic [3:0] r_cnt;
  state_t     r_state;
  logic [1:0] r_comma_cnt;
  logic [2:0] r_err_cnt;
  logic [1:0] r_good_run;
  logic [9:0] r_dout;
  logic       r_dout_valid;
  logic       r_comma_det;
  logic       r_realign;
  logic       r_sync_status;

  logic [9:0] w_sr_shift;
  logic       w_match;
  logic       w_cnt_last;
  logic       w_aligned;
  logic       w_realign;
  logic       w_boundary;
  logic       w_err_hit;

  // Boundary decode: the window including the incoming bit decides both framing and comma detection
  always_comb begin
    w_sr_shift = {rx_bit, r_sr[9:1]};
    w_cnt_last = (r_cnt == 4'd9);
    if (rx_bit_valid) begin
      w_match = is_k28_5(w_sr_shift);
    end else begin
      w_match = 1'b0;
    end
    w_aligned  = rx_bit_valid & w_cnt_last;
    // An aligned comma is already on the boundary, so only off-boundary commas count as realignment
    w_realign  = w_match & ~w_cnt_last & align_en & (r_state != ST_SYNC);
    w_boundary = w_aligned | w_realign;
    w_err_hit  = code_err_valid & code_err;
  end

  // Bit shifting, word framing and registered word outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sr         <= 10'd0;
      r_cnt        <= 4'd0;
      r_dout       <= 10'd0;
      r_dout_valid <= 1'b0;
      r_comma_det  <= 1'b0;
      r_realign    <= 1'b0;
    end else begin
      r_dout_valid <= 1'b0;
      r_realign    <= 1'b0;
      if (rx_bit_valid) begin
        r_sr <= w_sr_shift;
        if (w_boundary) begin
          r_cnt <= 4'd0;
        end else begin
          r_cnt <= r_cnt + 4'd1;
        end
      end
      if (w_boundary) begin
        r_dout       <= w_sr_shift;
        r_dout_valid <= 1'b1;
        r_comma_det  <= w_match;
        r_realign    <= w_realign;
      end
    end
  end

  // Link synchronisation state machine; a decoder error always wins over a coincident comma
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_LOS;
      r_comma_cnt   <= 2'd0;
      r_err_cnt     <= 3'd0;
      r_good_run    <= 2'd0;
      r_sync_status <= 1'b0;
    end else begin
      r_sync_status <= (r_state == ST_SYNC);
      case (r_state)
        ST_LOS: begin
          if (w_boundary && w_match && align_en) begin
            r_state     <= ST_ACQ;
            r_comma_cnt <= 2'd1;
          end
        end
        ST_ACQ: begin
          if (w_err_hit) begin
            r_state     <= ST_LOS;
            r_comma_cnt <= 2'd0;
          end else if (w_realign) begin
            r_comma_cnt <= 2'd1;
          end else if (w_aligned && w_match) begin
            if (r_comma_cnt == 2'd2) begin
              r_state     <= ST_SYNC;
              r_comma_cnt <= 2'd0;
              r_err_cnt   <= 3'd0;
              r_good_run  <= 2'd0;
            end else begin
              r_comma_cnt <= r_comma_cnt + 2'd1;
            end
          end
        end
        ST_SYNC: begin
          if (code_err_valid) begin
            if (code_err) begin
              // The fourth outstanding error drops the link instead of being stored
              if (r_err_cnt == 3'd3) begin
                r_state     <= ST_LOS;
                r_comma_cnt <= 2'd0;
                r_err_cnt   <= 3'd0;
                r_good_run  <= 2'd0;
              end else begin
                r_err_cnt  <= r_err_cnt + 3'd1;
                r_good_run <= 2'd0;
              end
            end else if (r_good_run == 2'd3) begin
              r_good_run <= 2'd0;
              if (r_err_cnt != 3'd0) begin
                r_err_cnt <= r_err_cnt - 3'd1;
              end
            end else begin
              r_good_run <= r_good_run + 2'd1;
            end
          end
        end
        default: begin
          r_state     <= ST_LOS;
          r_comma_cnt <= 2'd0;
          r_err_cnt   <= 3'd0;
          r_good_run  <= 2'd0;
        end
      endcase
    end
  end

  assign dout        = r_dout;
  assign dout_valid  = r_dout_valid;
  assign comma_det   = r_comma_det;
  assign realign     = r_realign;
  assign sync_status = r_sync_status;

  comma_aligner_chk u_chk (
    .clk        (clk),
    .reset      (reset),
    .dout_valid (r_dout_valid),
    .realign    (r_realign),
    .cnt        (r_cnt)
  );

endmodule

// File: tb/tb_comma_aligner.sv
// Randomised bench for comma_aligner against a queue-based reference model of
// word framing and link synchronisation.

module tb_comma_aligner;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_bit, rx_bit_valid, align_en, code_err, code_err_valid;
  logic [9:0] dout;
  logic       dout_valid, comma_det, realign, sync_status;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  comma_aligner dut (
    .clk            (clk),
    .reset          (reset),
    .rx_bit         (rx_bit),
    .rx_bit_valid   (rx_bit_valid),
    .align_en       (align_en),
    .code_err       (code_err),
    .code_err_valid (code_err_valid),
    .dout           (dout),
    .dout_valid     (dout_valid),
    .comma_det      (comma_det),
    .realign        (realign),
    .sync_status    (sync_status)
  );

  localparam int M_LOS = 0, M_ACQ = 1, M_SYNC = 2;

  // Reference model: last ten received bits (oldest first), bits since last boundary, link state
  int         m_bits[$];
  int         m_pos, m_state, m_commas, m_errs, m_goods;
  logic [9:0] e_dout;
  bit         e_dv, e_cd, e_ra, e_sync;
  int         ra_seen;

  function automatic void model_reset();
    m_bits.delete();
    for (int i = 0; i < 10; i++) m_bits.push_back(0);
    m_pos = 0; m_state = M_LOS; m_commas = 0; m_errs = 0; m_goods = 0;
    e_dout = 10'd0; e_dv = 1'b0; e_cd = 1'b0; e_ra = 1'b0; e_sync = 1'b0;
  endfunction

  function automatic void model_step(input bit b, input bit v, input bit ae, input bit ce, input bit cev);
    int word;
    bit aligned, acc_ra, match;
    e_sync = (m_state == M_SYNC);
    e_dv = 1'b0; e_ra = 1'b0;
    aligned = 1'b0; acc_ra = 1'b0; match = 1'b0;
    if (v) begin
      void'(m_bits.pop_front());
      m_bits.push_back(int'(b));
      word = 0;
      for (int i = 0; i < 10; i++) word += m_bits[i] * (1 << i);
      match   = (word == 380) || (word == 643);
      aligned = (m_pos == 9);
      acc_ra  = !aligned && match && ae && (m_state != M_SYNC);
      if (aligned || acc_ra) begin
        e_dout = 10'(word); e_dv = 1'b1; e_cd = match; e_ra = acc_ra; m_pos = 0;
      end else begin
        m_pos++;
      end
    end
    if (m_state == M_LOS) begin
      if ((aligned || acc_ra) && match && ae) begin m_state = M_ACQ; m_commas = 1; end
    end else if (m_state == M_ACQ) begin
      if (cev && ce) begin m_state = M_LOS; m_commas = 0; end
      else if (acc_ra) m_commas = 1;
      else if (aligned && match) begin
        m_commas++;
        if (m_commas == 3) begin m_state = M_SYNC; m_errs = 0; m_goods = 0; end
      end
    end else if (cev) begin
      if (ce) begin
        m_errs++; m_goods = 0;
        if (m_errs == 4) begin m_state = M_LOS; m_commas = 0; m_errs = 0; end
      end else begin
        m_goods++;
        if (m_goods == 4) begin m_goods = 0; if (m_errs > 0) m_errs--; end
      end
    end
  endfunction

  task automatic drive(input bit b, input bit v, input bit ae, input bit ce, input bit cev);
    rx_bit = b; rx_bit_valid = v; align_en = ae; code_err = ce; code_err_valid = cev;
    model_step(b, v, ae, ce, cev);
    @(posedge clk); #1;
    ra_seen += int'(realign);
  endtask

  task automatic apply_reset();
    rx_bit = 1'b0; rx_bit_valid = 1'b0; align_en = 1'b0; code_err = 1'b0; code_err_valid = 1'b0;
    reset = 1'b1;
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic send_word(input logic [9:0] w, input bit ae);
    for (int i = 0; i < 10; i++) drive(w[i], 1'b1, ae, 1'b0, 1'b0);
  endtask

  task automatic go_sync();
    apply_reset();
    send_word(10'h17C, 1'b1); send_word(10'h283, 1'b1); send_word(10'h17C, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx_bit = 1'b0; rx_bit_valid = 1'b0; align_en = 1'b0; code_err = 1'b0; code_err_valid = 1'b0;
    model_reset();
    @(posedge clk); #1;
    checks++;
    if ({dout, dout_valid, comma_det, realign, sync_status} !== 14'd0) begin
      errors++; $display("FAIL reset_init: outputs=%h expected 0", {dout, dout_valid, comma_det, realign, sync_status});
    end
    reset = 1'b0;
    send_word(10'h17C, 1'b1); send_word(10'h283, 1'b1); send_word(10'h17C, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (sync_status !== 1'b1 || dout !== 10'h17C) begin
      errors++; $display("FAIL reset_presync: sync=%b dout=%h expected 1 17c", sync_status, dout);
    end
    #3 reset = 1'b1;
    #1;
    checks++;
    if ({dout, dout_valid, comma_det, realign, sync_status} !== 14'd0) begin
      errors++; $display("FAIL reset_midstream: outputs=%h expected 0", {dout, dout_valid, comma_det, realign, sync_status});
    end
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_realign();
    bit q[$];
    logic [9:0] k = 10'h17C;
    apply_reset();
    for (int i = 0; i < 3; i++) q.push_back(1'($urandom_range(0, 1)));
    for (int i = 0; i < 10; i++) q.push_back(k[i]);
    foreach (q[i]) begin
      drive(q[i], 1'b1, 1'b1, 1'b0, 1'b0);
      checks++;
      if (dout_valid !== e_dv || realign !== e_ra || sync_status !== e_sync || dout !== e_dout || (e_dv && comma_det !== e_cd)) begin
        errors++; $display("FAIL realign_seq bit %0d: dv/ra/sync/cd/dout=%b/%b/%b/%b/%h expected %b/%b/%b/%b/%h", i, dout_valid, realign, sync_status, comma_det, dout, e_dv, e_ra, e_sync, e_cd, e_dout);
      end
    end
    checks++;
    if ({realign, dout_valid, comma_det} !== 3'b111 || dout !== 10'h17C) begin
      errors++; $display("FAIL realign_word: ra/dv/cd=%b%b%b dout=%h expected 111 17c", realign, dout_valid, comma_det, dout);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (realign !== 1'b0 || dout_valid !== 1'b0 || dout !== 10'h17C) begin
      errors++; $display("FAIL realign_pulse: ra/dv=%b%b dout=%h expected 00 17c", realign, dout_valid, dout);
    end
  endtask

  task automatic test_sync();
    logic [9:0] words[3] = '{10'h17C, 10'h283, 10'h17C};
    apply_reset();
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 10; i++) begin
        drive(words[w][i], 1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (dout_valid !== e_dv || realign !== e_ra || sync_status !== e_sync || dout !== e_dout || (e_dv && comma_det !== e_cd)) begin
          errors++; $display("FAIL sync_seq w%0d b%0d: dv/ra/sync/cd/dout=%b/%b/%b/%b/%h expected %b/%b/%b/%b/%h", w, i, dout_valid, realign, sync_status, comma_det, dout, e_dv, e_ra, e_sync, e_cd, e_dout);
        end
      end
    end
    checks++;
    if (dout_valid !== 1'b1 || comma_det !== 1'b1 || sync_status !== 1'b0) begin
      errors++; $display("FAIL sync_third_word: dv/cd/sync=%b%b%b expected 110", dout_valid, comma_det, sync_status);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (sync_status !== 1'b1) begin
      errors++; $display("FAIL sync_status_rise: got %b expected 1", sync_status);
    end
  endtask

  task automatic test_late_comma();
    bit q[$];
    logic [9:0] k = 10'h17C;
    for (int i = 0; i < 12; i++) q.push_back(1'($urandom_range(0, 1)));
    for (int i = 0; i < 10; i++) q.push_back(k[i]);
    for (int i = 0; i < 8; i++) q.push_back(1'($urandom_range(0, 1)));
    ra_seen = 0;
    foreach (q[i]) begin
      drive(q[i], 1'b1, 1'b1, 1'b0, 1'b0);
      checks++;
      if (dout_valid !== e_dv || realign !== e_ra || sync_status !== e_sync || dout !== e_dout || (e_dv && comma_det !== e_cd)) begin
        errors++; $display("FAIL late_comma bit %0d: dv/ra/sync/cd/dout=%b/%b/%b/%b/%h expected %b/%b/%b/%b/%h", i, dout_valid, realign, sync_status, comma_det, dout, e_dv, e_ra, e_sync, e_cd, e_dout);
      end
    end
    checks++;
    if (ra_seen != 0 || sync_status !== 1'b1) begin
      errors++; $display("FAIL late_comma_ignored: realigns=%0d sync=%b expected 0 1", ra_seen, sync_status);
    end
  endtask

  task automatic test_err_loss();
    go_sync();
    for (int e = 0; e < 4; e++) begin
      int goods = $urandom_range(0, 3);
      for (int g = 0; g <= goods; g++) begin
        drive(1'b0, 1'b0, 1'b1, (g == goods), 1'b1);
        checks++;
        if (sync_status !== e_sync || dout_valid !== e_dv) begin
          errors++; $display("FAIL err_loss e%0d g%0d: sync/dv=%b%b expected %b%b", e, g, sync_status, dout_valid, e_sync, e_dv);
        end
      end
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (sync_status !== 1'b0) begin
      errors++; $display("FAIL err_loss_drop: sync=%b expected 0", sync_status);
    end
  endtask

  task automatic test_err_tolerate();
    go_sync();
    for (int e = 0; e < 6; e++) begin
      for (int g = 0; g < 5; g++) begin
        drive(1'b0, 1'b0, 1'b1, (g == 0), 1'b1);
        checks++;
        if (sync_status !== e_sync) begin
          errors++; $display("FAIL err_tolerate e%0d g%0d: sync=%b expected %b", e, g, sync_status, e_sync);
        end
      end
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (sync_status !== 1'b1) begin
      errors++; $display("FAIL err_tolerate_hold: sync=%b expected 1", sync_status);
    end
  endtask

  task automatic test_align_dis();
    bit q[$];
    bit ae[$];
    logic [9:0] k1 = 10'h17C;
    logic [9:0] k2 = 10'h283;
    apply_reset();
    for (int i = 0; i < 3; i++) begin q.push_back(1'($urandom_range(0, 1))); ae.push_back(1'b0); end
    for (int i = 0; i < 10; i++) begin q.push_back(k1[i]); ae.push_back(1'b0); end
    for (int i = 0; i < 7; i++) begin q.push_back(1'b0); ae.push_back(1'b0); end
    for (int i = 0; i < 10; i++) begin q.push_back(k1[i]); ae.push_back(1'b1); end
    for (int i = 0; i < 10; i++) begin q.push_back(k2[i]); ae.push_back(1'b1); end
    ra_seen = 0;
    foreach (q[i]) begin
      drive(q[i], 1'b1, ae[i], 1'b0, 1'b0);
      checks++;
      if (dout_valid !== e_dv || realign !== e_ra || sync_status !== e_sync || dout !== e_dout || (e_dv && comma_det !== e_cd)) begin
        errors++; $display("FAIL align_dis bit %0d: dv/ra/sync/cd/dout=%b/%b/%b/%b/%h expected %b/%b/%b/%b/%h", i, dout_valid, realign, sync_status, comma_det, dout, e_dv, e_ra, e_sync, e_cd, e_dout);
      end
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (ra_seen != 0 || sync_status !== 1'b0) begin
      errors++; $display("FAIL align_dis_los: realigns=%0d sync=%b expected 0 0", ra_seen, sync_status);
    end
  endtask

  task automatic test_err_comma_collision();
    logic [9:0] k = 10'h283;
    apply_reset();
    send_word(10'h17C, 1'b1);
    for (int i = 0; i < 10; i++) drive(k[i], 1'b1, 1'b1, (i == 9), (i == 9));
    checks++;
    if (dout_valid !== 1'b1 || comma_det !== 1'b1 || dout !== 10'h283) begin
      errors++; $display("FAIL collision_word: dv/cd=%b%b dout=%h expected 11 283", dout_valid, comma_det, dout);
    end
    send_word(10'h17C, 1'b1); send_word(10'h283, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (sync_status !== 1'b0 || sync_status !== e_sync) begin
      errors++; $display("FAIL collision_los: sync=%b expected 0", sync_status);
    end
  endtask

  task automatic test_random();
    bit src[$];
    apply_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 699) == 0) begin
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({dout, dout_valid, comma_det, realign, sync_status} !== 14'd0) begin
          errors++; $display("FAIL random_reset cyc %0d: outputs=%h expected 0", c, {dout, dout_valid, comma_det, realign, sync_status});
        end
        model_reset();
        src.delete();
        @(posedge clk); #1;
        reset = 1'b0;
      end
      if (src.size() == 0) begin
        if ($urandom_range(0, 1) == 1) begin
          logic [9:0] k;
          k = ($urandom_range(0, 1) == 1) ? 10'h17C : 10'h283;
          for (int i = 0; i < 10; i++) src.push_back(k[i]);
        end else begin
          int n = $urandom_range(1, 12);
          for (int i = 0; i < n; i++) src.push_back(1'($urandom_range(0, 1)));
        end
      end
      begin
        bit v = ($urandom_range(0, 3) != 0);
        bit b = v ? src[0] : 1'b0;
        if (v) void'(src.pop_front());
        drive(b, v, ($urandom_range(0, 7) != 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0));
      end
      checks++;
      if (dout_valid !== e_dv || realign !== e_ra || sync_status !== e_sync || dout !== e_dout || (e_dv && comma_det !== e_cd)) begin
        errors++; $display("FAIL random cyc %0d: dv/ra/sync/cd/dout=%b/%b/%b/%b/%h expected %b/%b/%b/%b/%h", c, dout_valid, realign, sync_status, comma_det, dout, e_dv, e_ra, e_sync, e_cd, e_dout);
      end
    end
  endtask

  initial begin
    ra_seen = 0;
    test_reset();
    test_realign();
    test_sync();
    test_late_comma();
    test_err_loss();
    test_err_tolerate();
    test_align_dis();
    test_err_comma_collision();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/comma_aligner.md
COMMA_ALIGNER -- requirements
Module: comma_aligner

Interface
REQ-001 SHALL have clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have rx_bit  input  1  recovered serial bit, transmit order a,b,c,d,e,i,f,g,h,j.
REQ-004 SHALL have rx_bit_valid  input  1  rx_bit qualifier, at most one bit per clk.
REQ-005 SHALL have align_en  input  1  permits boundary realignment on comma.
REQ-006 SHALL have code_err  input  1  downstream decoder code/disparity error for one word.
REQ-007 SHALL have code_err_valid  input  1  code_err qualifier, one pulse per decoded word.
REQ-008 SHALL have dout  output  10  aligned word, dout[0]=a ... dout[9]=j, feeds 8B/10B decoder din.
REQ-009 SHALL have dout_valid  output  1  one-cycle strobe per aligned word.
REQ-010 SHALL have comma_det  output  1  dout is K28.5, valid with dout_valid.
REQ-011 SHALL have realign  output  1  one-cycle pulse, word boundary moved.
REQ-012 SHALL have sync_status  output  1  high in SYNC state.

Function
REQ-013 SHALL keep 10-bit shift register sr; on rx_bit_valid: sr_next = {rx_bit, sr[9:1]}, sr <= sr_next.
REQ-014 SHALL define comma match as sr_next == 10'h17C (K28.5 RD-) or 10'h283 (K28.5 RD+).
REQ-015 SHALL keep bit counter cnt 0..9; word boundary when rx_bit_valid and cnt==9; then cnt <= 0, else cnt <= cnt+1 (wraps 9->0 only).
REQ-016 SHALL accept realignment when rx_bit_valid, comma match, cnt!=9, align_en=1, state!=SYNC: cnt <= 0, treated as word boundary, realign pulses 1 cycle.
REQ-017 SHALL, on every word boundary (normal or realign), register dout <= sr_next, dout_valid <= 1, comma_det <= match, next cycle (latency 1 clk from 10th bit).
REQ-018 SHALL drive dout_valid, realign low in all other cycles; dout holds last value.
REQ-019 SHALL ignore misaligned commas (no realign, cnt unchanged) in SYNC or when align_en=0.
REQ-020 SHALL implement FSM states LOS, ACQ, SYNC; counters comma_cnt (2b), err_cnt (3b), good_run (2b).
REQ-021 SHALL, in LOS, on any accepted comma boundary (aligned or realigned, align_en=1) -> ACQ, comma_cnt=1.
REQ-022 SHALL, in ACQ, on aligned comma boundary increment comma_cnt; reaching 3 -> SYNC, clear err_cnt, good_run.
REQ-023 SHALL, in ACQ, on accepted realign set comma_cnt=1, remain ACQ.
REQ-024 SHALL, in ACQ, on code_err_valid&code_err -> LOS, clear comma_cnt.
REQ-025 SHALL ignore code_err_valid in LOS.
REQ-026 SHALL, in SYNC on code_err_valid: error -> err_cnt+1, good_run=0; good -> good_run+1; good_run reaching 4 -> err_cnt saturating decrement at 0, good_run=0.
REQ-027 SHALL, when err_cnt reaches 4, go SYNC -> LOS next cycle, clear all FSM counters.
REQ-028 SHALL, on simultaneous error-driven LOS transition and comma in same cycle, take LOS; comma not counted; word output unaffected.
REQ-029 SHALL drive sync_status = (state==SYNC), registered.

Reset
REQ-030 SHALL on reset asynchronously set sr=0, cnt=0, state=LOS, all counters 0, dout=0, dout_valid=0, comma_det=0, realign=0, sync_status=0.
REQ-031 SHALL resume bit counting from cnt=0 on first rx_bit_valid after reset release; reset mid-word discards partial word.

Verification
REQ-032 SHALL check: reset asserted mid-stream -> all outputs 0 same cycle, sync_status 0.
REQ-033 SHALL check: 3 random bits then 10'h17C LSB-first, align_en=1 -> realign=1, dout=10'h17C, dout_valid=1, comma_det=1, state ACQ.
REQ-034 SHALL check: three aligned K28.5 words (17C,283,17C) from LOS -> sync_status=1 cycle after third dout_valid.
REQ-035 SHALL check: in SYNC, K28.5 injected 2 bits late -> realign=0, dout boundaries unchanged, sync_status stays 1.
REQ-036 SHALL check: in SYNC, 4 code_err pulses with <=3 good words between -> sync_status=0; with 4 good words between each error -> stays 1.
REQ-037 SHALL check: align_en=0 in LOS with misaligned comma -> no realign, state stays LOS.
